mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-access stage directly downstream of the combined EX/MEM passthrough. It consumes the registered memory-op fields (qm_a1 address, qm_a2 store data, qm_r1_op kind, qm_r2_op size) and runs one request/acknowledge transaction per op on the data bus. It returns load data, and generates the r_proceed flag that the passthrough forwards to writeback. It stalls upstream while a bus transaction is outstanding.

Parameters:
TIMEOUT, 255, bus-wait cycles before abort (used only with MEM_TIMEOUT_EN); 8-bit range 1..255

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
m_a1  input  32  byte address (from qm_a1)
m_a2  input  32  store data (from qm_a2)
m_r1_op  input  4  access kind: 0 NOP, 1 LOAD, 2 STORE, others = NOP
m_r2_op  input  4  size: 0 word, 1 half-u, 2 half-s, 3 byte-u, 4 byte-s, others = word
bus_addr  output  32  word-aligned address ({a[31:2],2'b00})
bus_wdata  output  32  store data, lane-replicated
bus_be  output  4  byte enables
bus_we  output  1  1 = write
bus_req  output  1  request, held until ack
bus_ack  input  1  transaction complete; rdata valid for reads
bus_rdata  input  32  read data
ld_data  output  32  extracted, extended load result
r_proceed  output  1  instruction completed this cycle (to passthrough r_proceed)
misalign  output  1  1-cycle pulse: misaligned access dropped
mem_stall  output  1  hold upstream; combinational, high while state = REQ
bus_err  output  1  1-cycle pulse: timeout abort

Behaviour:
- Reset (rst = 0, async): state IDLE, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, ld_data 0, r_proceed 0, misalign 0, bus_err 0, timeout counter 0. Reset mid-transaction drops bus_req immediately. No completion is reported for the aborted op.
- States: IDLE, REQ.
- IDLE, each rising edge, samples the inputs:
  - NOP: r_proceed <= 1 next cycle; stay IDLE.
  - LOAD/STORE, aligned: latch bus_addr, bus_we, bus_be, bus_wdata and the size code; bus_req <= 1; go to REQ; r_proceed <= 0.
  - Misaligned (word with a[1:0] != 0, half with a[0] != 0): no bus cycle; misalign <= 1 for one cycle; r_proceed <= 0; stay IDLE.
- Alignment and lanes, k = a[1:0]:
  - byte: be = 1 << k; wdata = {4{a2[7:0]}}.
  - half: be = k[1] ? 4'b1100 : 4'b0011; wdata = {2{a2[15:0]}}.
  - word: be = 4'b1111; wdata = a2.
  - Loads drive the same be, with bus_we = 0.
- REQ:
  - All bus outputs are held stable.
  - bus_ack sampled 1: bus_req <= 0; r_proceed <= 1 for one cycle; return to IDLE.
  - On a LOAD completion, ld_data <= extracted lane with sign/zero extension per the size code, and keeps that value until the next load completes.
  - STORE completion leaves ld_data unchanged.
- Inputs sampled while in REQ are ignored; upstream holds them because mem_stall = 1.
- Minimum latency: op sampled at edge N, bus_req high from N+1. Ack at edge M ≥ N+1 gives r_proceed high in the cycle after M and state IDLE. The next op is sampled at edge M+1 (one bubble cycle).
- bus_ack while IDLE is ignored.
- r_proceed, misalign and bus_err are registered and mutually exclusive in any cycle.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to REQ and increments each cycle in REQ without ack. When it reaches TIMEOUT, the unit drops bus_req, pulses bus_err for 1 cycle, keeps r_proceed 0 and returns to IDLE. Ack on the same edge the counter reaches TIMEOUT wins: normal completion, no bus_err.
- Undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Test Plan:
1. Reset low then high; m_r1_op = 0 held → all outputs 0 during reset; r_proceed = 1 from the second cycle after release, mem_stall = 0.
2. STORE byte, a1 = 0x1003, a2 = 0xA5; ack after 3 cycles → bus_addr = 0x1000, be = 4'b1000, wdata = 0xA5A5A5A5, we = 1; mem_stall high 3 cycles; single r_proceed pulse after ack; ld_data unchanged.
3. LOAD half-s, a1 = 0x2002; rdata = 0x8001_1234; ack next cycle → be = 4'b1100; ld_data = 0xFFFF8001. Repeat with half-u → 0x00008001.
4. LOAD word, a1 = 0x3001 → no bus_req; misalign pulse; r_proceed 0; next NOP gives r_proceed 1.
5. Assert rst low while in REQ with bus_req high → bus_req 0 immediately; after release, state IDLE and ack is ignored.
6. (MEM_TIMEOUT_EN, TIMEOUT = 4) LOAD with no ack → bus_req drops after 4 wait cycles; bus_err 1-cycle pulse; r_proceed 0. Ack on the 4th wait cycle → normal completion, no bus_err.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : memory-access stage; one req/ack bus transaction per op.
// Optional macro MEM_TIMEOUT_EN adds a TIMEOUT-cycle bus-wait abort.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_a1,
  input  logic [31:0] m_a2,
  input  logic [3:0]  m_r1_op,
  input  logic [3:0]  m_r2_op,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic        bus_req,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data,
  output logic        r_proceed,
  output logic        misalign,
  output logic        mem_stall,
  output logic        bus_err
);
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  localparam logic [3:0] C_OP_LOAD  = 4'd1;
  localparam logic [3:0] C_OP_STORE = 4'd2;

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("mem_access_unit: TIMEOUT must lie in 1..255");
  end

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, ld_q;
  logic [3:0]  be_q, size_q;
  logic [1:0]  ofs_q;
  logic        we_q, req_q, proceed_q, misalign_q;

  logic [1:0]  w_k;
  logic        w_is_byte, w_is_half, w_is_mem, w_aligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_d;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_k       = m_a1[1:0];
    w_is_byte = (m_r2_op == 4'd3) || (m_r2_op == 4'd4);
    w_is_half = (m_r2_op == 4'd1) || (m_r2_op == 4'd2);
    w_is_mem  = (m_r1_op == C_OP_LOAD) || (m_r1_op == C_OP_STORE);
    if (w_is_byte) begin
      be_d      = 4'b0001 << w_k;
      wdata_d   = {4{m_a2[7:0]}};
      w_aligned = 1'b1;
    end else if (w_is_half) begin
      be_d      = w_k[1] ? 4'b1100 : 4'b0011;
      wdata_d   = {2{m_a2[15:0]}};
      w_aligned = ~w_k[0];
    end else begin
      be_d      = 4'b1111;
      wdata_d   = m_a2;
      w_aligned = (w_k == 2'b00);
    end
  end

  // Lane extraction uses the offset latched at request time, not the live input.
  always_comb begin
    w_half = ofs_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ofs_q)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    case (size_q)
      4'd1:    ld_d = {16'h0000, w_half};
      4'd2:    ld_d = {{16{w_half[15]}}, w_half};
      4'd3:    ld_d = {24'h000000, w_byte};
      4'd4:    ld_d = {{24{w_byte[7]}}, w_byte};
      default: ld_d = bus_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;
  logic       err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_q       <= '0;
      be_q       <= '0;
      size_q     <= '0;
      ofs_q      <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      proceed_q  <= 1'b0;
      misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      proceed_q  <= 1'b0;
      misalign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!w_is_mem) begin
            proceed_q <= 1'b1;
          end else if (!w_aligned) begin
            misalign_q <= 1'b1;
          end else begin
            addr_q  <= {m_a1[31:2], 2'b00};
            we_q    <= (m_r1_op == C_OP_STORE);
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= m_r2_op;
            ofs_q   <= w_k;
            req_q   <= 1'b1;
            state_q <= S_REQ;
`ifdef MEM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        S_REQ: begin
          // An ack on the same edge as the timeout limit still completes normally.
          if (bus_ack) begin
            req_q     <= 1'b0;
            proceed_q <= 1'b1;
            state_q   <= S_IDLE;
            if (!we_q) ld_q <= ld_d;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_q == C_TMO_LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign bus_we    = we_q;
  assign bus_req   = req_q;
  assign ld_data   = ld_q;
  assign r_proceed = proceed_q;
  assign misalign  = misalign_q;
  assign mem_stall = (state_q == S_REQ);
`ifdef MEM_TIMEOUT_EN
  assign bus_err   = err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// Testbench for mem_access_unit: directed scenarios plus randomized ops checked
// against a byte-level reference model of the load/store lane rules.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] m_a1 = '0, m_a2 = '0, bus_rdata = '0;
  logic [3:0]  m_r1_op = '0, m_r2_op = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, ld_data;
  logic [3:0]  bus_be;
  logic        bus_we, bus_req, r_proceed, misalign, mem_stall, bus_err;

  int total = 0, bad = 0;
  logic [31:0] ld_exp = '0;

  // Observations collected by run_op
  logic        o_req, o_we, o_mis, o_pro0, o_pro_after, o_err_after;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_be;
  int          o_stalls, o_pro_during, o_unstable;
  bit          o_hung;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .m_a1(m_a1), .m_a2(m_a2), .m_r1_op(m_r1_op), .m_r2_op(m_r2_op),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
    .bus_req(bus_req), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ld_data(ld_data),
    .r_proceed(r_proceed), .misalign(misalign), .mem_stall(mem_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [3:0] size);
    case (size)
      4'd1, 4'd2: return 2;
      4'd3, 4'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_mem(input logic [3:0] kind);
    return (kind == 4'd1) || (kind == 4'd2);
  endfunction

  function automatic bit m_aligned(input logic [3:0] size, input logic [31:0] a);
    return (a % nbytes(size)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] size, input logic [31:0] a);
    int k = int'(a % 4);
    int nb = nbytes(size);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) if (i >= k && i < k + nb) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] size, input logic [31:0] d);
    int nb = nbytes(size);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_ld(input logic [3:0] size, input logic [31:0] a, input logic [31:0] rd);
    int k = int'(a % 4);
    int nb = nbytes(size);
    longint v = (longint'(rd) >> (8*k)) & ((64'sd1 << (8*nb)) - 1);
    if ((size == 4'd2 || size == 4'd4) && v >= (64'sd1 << (8*nb - 1))) v = v - (64'sd1 << (8*nb));
    return v[31:0];
  endfunction

  // ---------------- driver (observes only) ----------------
  task automatic run_op(input logic [3:0] kind, input logic [3:0] size, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] rd, input int ack_delay);
    m_r1_op = kind; m_r2_op = size; m_a1 = a1; m_a2 = a2; bus_rdata = rd; bus_ack = 1'b0;
    @(posedge clk); #1;
    m_r1_op = 4'd0;
    o_req = bus_req; o_we = bus_we; o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata;
    o_mis = misalign; o_pro0 = r_proceed;
    o_stalls = 0; o_pro_during = 0; o_unstable = 0; o_hung = 0;
    while (mem_stall === 1'b1 && !o_hung) begin
      o_stalls++;
      if (r_proceed !== 1'b0) o_pro_during++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, o_we, o_addr, o_be, o_wdata}) o_unstable++;
      if (o_stalls == ack_delay) bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (o_stalls >= 300) o_hung = 1;
    end
    o_pro_after = r_proceed; o_err_after = bus_err; o_ld = ld_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; m_r1_op = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, r_proceed, misalign, bus_err, mem_stall} !== '0) begin
      bad++; $display("FAIL reset_outputs: got req=%b we=%b be=%h addr=%h wd=%h ld=%h pro=%b mis=%b err=%b stall=%b want all 0",
                      bus_req, bus_we, bus_be, bus_addr, bus_wdata, ld_data, r_proceed, misalign, bus_err, mem_stall);
    end
    rst = 1'b1;
    #1;
    total++; if (r_proceed !== 1'b0) begin bad++; $display("FAIL reset_release_first: got pro=%b want 0", r_proceed); end
    @(posedge clk); #1;
    total++; if (r_proceed !== 1'b1) begin bad++; $display("FAIL reset_release_proceed: got %b want 1", r_proceed); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL reset_release_stall: got %b want 0", mem_stall); end
    ld_exp = '0;
  endtask

  task automatic test_store_byte();
    run_op(4'd2, 4'd3, 32'h0000_1003, 32'h0000_00A5, 32'h0, 3);
    total++; if (o_addr !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr: got %h want 00001000", o_addr); end
    total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", o_be); end
    total++; if (o_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata); end
    total++; if (o_we !== 1'b1 || o_req !== 1'b1) begin bad++; $display("FAIL sb_we_req: got we=%b req=%b want 1 1", o_we, o_req); end
    total++; if (o_stalls !== 3) begin bad++; $display("FAIL sb_stall_cycles: got %0d want 3", o_stalls); end
    total++; if (o_pro0 !== 1'b0 || o_pro_during !== 0 || o_pro_after !== 1'b1) begin
      bad++; $display("FAIL sb_proceed: got start=%b during=%0d after=%b want 0 0 1", o_pro0, o_pro_during, o_pro_after); end
    total++; if (o_unstable !== 0) begin bad++; $display("FAIL sb_bus_stable: got %0d changes want 0", o_unstable); end
    total++; if (o_ld !== ld_exp) begin bad++; $display("FAIL sb_ld_unchanged: got %h want %h", o_ld, ld_exp); end
  endtask

  task automatic test_load_half();
    run_op(4'd1, 4'd2, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
    total++; if (o_be !== 4'b1100 || o_we !== 1'b0) begin bad++; $display("FAIL lh_be_we: got be=%b we=%b want 1100 0", o_be, o_we); end
    total++; if (o_ld !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_signed: got %h want ffff8001", o_ld); end
    total++; if (o_stalls !== 1 || o_pro_after !== 1'b1) begin bad++; $display("FAIL lh_latency: got stalls=%0d pro=%b want 1 1", o_stalls, o_pro_after); end
    run_op(4'd1, 4'd1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1);
    total++; if (o_ld !== 32'h0000_8001) begin bad++; $display("FAIL lh_unsigned: got %h want 00008001", o_ld); end
    ld_exp = 32'h0000_8001;
  endtask

  task automatic test_misalign();
    run_op(4'd1, 4'd0, 32'h0000_3001, 32'h0, 32'hDEAD_BEEF, 1);
    total++; if (o_req !== 1'b0 || o_stalls !== 0) begin bad++; $display("FAIL mis_no_req: got req=%b stalls=%0d want 0 0", o_req, o_stalls); end
    total++; if (o_mis !== 1'b1 || o_pro0 !== 1'b0) begin bad++; $display("FAIL mis_pulse: got mis=%b pro=%b want 1 0", o_mis, o_pro0); end
    @(posedge clk); #1;
    total++; if (misalign !== 1'b0 || r_proceed !== 1'b1) begin bad++; $display("FAIL mis_then_nop: got mis=%b pro=%b want 0 1", misalign, r_proceed); end
    total++; if (ld_data !== ld_exp) begin bad++; $display("FAIL mis_ld: got %h want %h", ld_data, ld_exp); end
  endtask

  task automatic test_idle_ack();
    m_r1_op = 4'd0; bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || r_proceed !== 1'b1) begin
      bad++; $display("FAIL idle_ack: got req=%b stall=%b pro=%b want 0 0 1", bus_req, mem_stall, r_proceed); end
    total++; if (ld_data !== ld_exp) begin bad++; $display("FAIL idle_ack_ld: got %h want %h", ld_data, ld_exp); end
    bus_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [3:0] kind, size;
      logic [31:0] a1, a2, rd;
      int sel, ad;
      sel  = $urandom_range(0, 9);
      kind = (sel < 4) ? 4'd1 : (sel < 8) ? 4'd2 : 4'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      a1 = $urandom; a2 = $urandom; rd = $urandom;
      if ($urandom_range(0, 1) == 1) a1[1:0] = 2'b00;
      ad = $urandom_range(1, 4);
      run_op(kind, size, a1, a2, rd, ad);
      if (!is_mem(kind)) begin
        total++; if (o_req !== 1'b0 || o_pro0 !== 1'b1 || o_mis !== 1'b0) begin
          bad++; $display("FAIL rnd_nop[%0d]: got req=%b pro=%b mis=%b want 0 1 0", it, o_req, o_pro0, o_mis); end
      end else if (!m_aligned(size, a1)) begin
        total++; if (o_req !== 1'b0 || o_mis !== 1'b1 || o_pro0 !== 1'b0) begin
          bad++; $display("FAIL rnd_misalign[%0d]: got req=%b mis=%b pro=%b want 0 1 0", it, o_req, o_mis, o_pro0); end
      end else begin
        if (kind == 4'd1) ld_exp = m_ld(size, a1, rd);
        total++; if ({o_addr, o_be, o_we} !== {a1 & 32'hFFFF_FFFC, m_be(size, a1), kind == 4'd2}) begin
          bad++; $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                          it, o_addr, o_be, o_we, a1 & 32'hFFFF_FFFC, m_be(size, a1), kind == 4'd2); end
        total++; if (o_wdata !== m_wdata(size, a2)) begin
          bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", it, o_wdata, m_wdata(size, a2)); end
        total++; if (o_stalls !== ad || o_unstable !== 0 || o_pro_during !== 0 || o_hung) begin
          bad++; $display("FAIL rnd_req_phase[%0d]: got stalls=%0d unstable=%0d pro=%0d want %0d 0 0", it, o_stalls, o_unstable, o_pro_during, ad); end
        total++; if (o_pro_after !== 1'b1 || o_err_after !== 1'b0) begin
          bad++; $display("FAIL rnd_complete[%0d]: got pro=%b err=%b want 1 0", it, o_pro_after, o_err_after); end
      end
      total++; if (o_ld !== ld_exp) begin bad++; $display("FAIL rnd_ld[%0d]: got %h want %h", it, o_ld, ld_exp); end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_op(4'd1, 4'd0, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0);
    total++; if (o_stalls !== 4 || o_hung) begin bad++; $display("FAIL tmo_wait: got %0d want 4", o_stalls); end
    total++; if (o_err_after !== 1'b1 || o_pro_after !== 1'b0 || bus_req !== 1'b0) begin
      bad++; $display("FAIL tmo_abort: got err=%b pro=%b req=%b want 1 0 0", o_err_after, o_pro_after, bus_req); end
    total++; if (o_ld !== ld_exp) begin bad++; $display("FAIL tmo_ld: got %h want %h", o_ld, ld_exp); end
    @(posedge clk); #1;
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got %b want 0", bus_err); end
    run_op(4'd1, 4'd0, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 4);
    total++; if (o_err_after !== 1'b0 || o_pro_after !== 1'b1 || o_ld !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL tmo_ack_wins: got err=%b pro=%b ld=%h want 0 1 cafef00d", o_err_after, o_pro_after, o_ld); end
    ld_exp = 32'hCAFE_F00D;
  endtask
`endif

  task automatic test_reset_mid();
    m_r1_op = 4'd1; m_r2_op = 4'd0; m_a1 = 32'h0000_4000; bus_rdata = 32'h1111_2222; bus_ack = 1'b0;
    @(posedge clk); #1;
    m_r1_op = 4'd0;
    total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rmid_req_up: got %b want 1", bus_req); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0 || mem_stall !== 1'b0 || ld_data !== 32'h0) begin
      bad++; $display("FAIL rmid_async: got req=%b stall=%b ld=%h want 0 0 0", bus_req, mem_stall, ld_data); end
    @(posedge clk); #1;
    rst = 1'b1; bus_ack = 1'b1;
    @(posedge clk); #1;
    total++; if (bus_req !== 1'b0 || r_proceed !== 1'b1 || ld_data !== 32'h0) begin
      bad++; $display("FAIL rmid_after: got req=%b pro=%b ld=%h want 0 1 0", bus_req, r_proceed, ld_data); end
    bus_ack = 1'b0;
    ld_exp = '0;
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_misalign();
    test_idle_ack();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
